// File: rtl/alu_result_fifo.sv
// Result buffer between the ALU and its consumer: stores {cout,z} beats in
// strict FIFO order and converts consumer back-pressure into a full-only stall.
module alu_result_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pushin,
  input  logic [DW-1:0]            z_in,
  input  logic                     cout_in,
  output logic                     stopout,
  output logic                     pushout,
  output logic [DW-1:0]            z,
  output logic                     cout,
  input  logic                     stopin,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  cnt;
  logic           ovf;
  logic           blk_p1;
  logic           wr_en;
  logic           rd_en;

  // Flags come only from registered occupancy, so stopin never reaches stopout.
  assign stopout  = (cnt == CW'(DEPTH));
  assign pushout  = (cnt != '0);
  assign count    = cnt;
  assign overflow = ovf;
  assign wr_en    = pushin && !stopout;
  assign rd_en    = pushout && !stopin;
  assign {cout, z} = pushout ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {cout_in, z_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      blk_p1 <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      // A beat held under stop is a retry; withdrawing it while still full loses it.
      blk_p1 <= pushin && stopout;
      if (blk_p1 && !pushin && stopout) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed vector table, reset/overflow sequences and
// randomized traffic checked against a queue-based reference model.
module tb_alu_result_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          pushin;
  logic [DW-1:0] z_in;
  logic          cout_in;
  logic          stopout;
  logic          pushout;
  logic [DW-1:0] z;
  logic          cout;
  logic          stopin;
  logic [CW-1:0] count;
  logic          overflow;

  alu_result_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pushin(pushin), .z_in(z_in), .cout_in(cout_in),
    .stopout(stopout), .pushout(pushout), .z(z), .cout(cout),
    .stopin(stopin), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW:0] mq[$];
  bit          m_ovf;
  bit          m_blk;

  typedef struct {
    logic          pin;
    logic [DW-1:0] zi;
    logic          ci;
    logic          sin;
    logic          epo;
    logic [DW-1:0] ez;
    logic          ec;
    int            ecnt;
    logic          eso;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [DW:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    chk({tag, ".pushout"},  32'(pushout),  32'(mq.size() != 0));
    chk({tag, ".z"},        32'(z),        32'(head[DW-1:0]));
    chk({tag, ".cout"},     32'(cout),     32'(head[DW]));
    chk({tag, ".count"},    32'(count),    32'(mq.size()));
    chk({tag, ".stopout"},  32'(stopout),  32'(mq.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // One clock edge: model decides transfers from the pre-edge inputs.
  task automatic tick(input string tag);
    bit full, wa, ra, ov;
    full  = (mq.size() == DEPTH);
    wa    = pushin && !full;
    ra    = (mq.size() != 0) && !stopin;
    ov    = m_blk && !pushin && full;
    m_blk = pushin && full;
    @(posedge clk);
    if (ra) void'(mq.pop_front());
    if (wa) mq.push_back({cout_in, z_in});
    if (ov) m_ovf = 1'b1;
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    pushin = 1'b0; z_in = '0; cout_in = 1'b0; stopin = 1'b0;
    rst = 1'b1;
    mq.delete(); m_ovf = 1'b0; m_blk = 1'b0;
    @(posedge clk); #1;
    check_model("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pushin = 1'b0; z_in = '0; cout_in = 1'b0; stopin = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_blk = 1'b0;
    #2;
    check_model("por");
    do_reset();

    // pin, z_in, cin, stopin | pushout, z, cout, count, stopout (after edge)
    tv[0]  = '{1'b1, 8'h5A, 1'b1, 1'b0,  1'b1, 8'h5A, 1'b1, 1, 1'b0};
    tv[1]  = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h00, 1'b0, 0, 1'b0};
    tv[2]  = '{1'b1, 8'h01, 1'b0, 1'b1,  1'b1, 8'h01, 1'b0, 1, 1'b0};
    tv[3]  = '{1'b1, 8'h02, 1'b1, 1'b1,  1'b1, 8'h01, 1'b0, 2, 1'b0};
    tv[4]  = '{1'b1, 8'h03, 1'b0, 1'b1,  1'b1, 8'h01, 1'b0, 3, 1'b0};
    tv[5]  = '{1'b1, 8'h04, 1'b1, 1'b1,  1'b1, 8'h01, 1'b0, 4, 1'b1};
    tv[6]  = '{1'b1, 8'h05, 1'b0, 1'b1,  1'b1, 8'h01, 1'b0, 4, 1'b1};
    tv[7]  = '{1'b1, 8'h05, 1'b0, 1'b1,  1'b1, 8'h01, 1'b0, 4, 1'b1};
    tv[8]  = '{1'b1, 8'h05, 1'b0, 1'b0,  1'b1, 8'h02, 1'b1, 3, 1'b0};
    tv[9]  = '{1'b1, 8'h05, 1'b0, 1'b0,  1'b1, 8'h03, 1'b0, 3, 1'b0};
    tv[10] = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 8'h04, 1'b1, 2, 1'b0};
    tv[11] = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 8'h05, 1'b0, 1, 1'b0};
    tv[12] = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h00, 1'b0, 0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      pushin = tv[i].pin; z_in = tv[i].zi; cout_in = tv[i].ci; stopin = tv[i].sin;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.pushout", i),  32'(pushout),  32'(tv[i].epo));
      chk($sformatf("vec%0d.z", i),        32'(z),        32'(tv[i].ez));
      chk($sformatf("vec%0d.cout", i),     32'(cout),     32'(tv[i].ec));
      chk($sformatf("vec%0d.count", i),    32'(count),    32'(tv[i].ecnt));
      chk($sformatf("vec%0d.stopout", i),  32'(stopout),  32'(tv[i].eso));
      chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(0));
    end

    // Asynchronous reset in the middle of a cycle with three entries held.
    do_reset();
    stopin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pushin = 1'b1; z_in = DW'(8'hC0 + i); cout_in = i[0];
      tick("t1fill");
    end
    pushin = 1'b0;
    #2 rst = 1'b1;
    mq.delete(); m_ovf = 1'b0; m_blk = 1'b0;
    #1;
    check_model("t1async");
    @(posedge clk); #1;
    rst = 1'b0;
    stopin = 1'b0;
    tick("t1resume");

    // Randomized traffic with legal ALU retry behaviour.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (!(pushin && stopout)) begin
        pushin  = ($urandom_range(0, 9) < 6);
        z_in    = DW'($urandom);
        cout_in = 1'($urandom);
      end
      stopin = ($urandom_range(0, 9) < 5);
      tick("rand");
    end
    pushin = 1'b0; stopin = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) tick("rdrain");

    // Withdrawn beat while full sets the sticky overflow flag.
    do_reset();
    stopin = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      pushin = 1'b1; z_in = DW'(8'h10 + i); cout_in = 1'b1;
      tick("ofill");
    end
    z_in = 8'hAA;
    tick("oheld");
    pushin = 1'b0;
    tick("odrop");
    chk("overflow.set", 32'(overflow), 32'(1));
    stopin = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) tick("osticky");
    chk("overflow.sticky", 32'(overflow), 32'(1));
    do_reset();
    chk("overflow.clear", 32'(overflow), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
